// File: rtl/dm_ctrl_pkg.sv
// Shared definitions for the data-memory access controller:
// size encodings, FSM states, latched request payload and the alignment rule.
package dm_ctrl_pkg;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      WB   = 2'd2
   } state_t;

   typedef struct packed {
      logic        we;
      logic [1:0]  size;
      logic [31:0] wdata;
   } acc_t;

   // Reserved size 11 is always misaligned.
   function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
      logic bad;
      case (size)
         SZ_BYTE: bad = 1'b0;
         SZ_HALF: bad = off[0];
         SZ_WORD: bad = |off;
         default: bad = 1'b1;
      endcase
      return bad;
   endfunction

endpackage

// File: rtl/dm_lane_merge.sv
// Little-endian lane handling: load extract with zero-extension, and
// sub-word store merge into an existing memory word.
module dm_lane_merge
   import dm_ctrl_pkg::*;
(
   input  logic [1:0]  size,
   input  logic [1:0]  off,
   input  logic [31:0] word,
   input  logic [31:0] data,
   output logic [31:0] load_data,
   output logic [31:0] store_data
);

   logic [4:0]  sh;
   logic [31:0] lane;
   logic [31:0] mask;

   // Halfword callers are aligned, so off*8 equals the halfword lane offset.
   always_comb begin
      sh         = {off, 3'b000};
      lane       = word >> sh;
      mask       = 32'h0;
      load_data  = word;
      store_data = data;
      case (size)
         SZ_BYTE: begin
            load_data  = {24'h0, lane[7:0]};
            mask       = 32'h0000_00FF << sh;
            store_data = (word & ~mask) | ({24'h0, data[7:0]} << sh);
         end
         SZ_HALF: begin
            load_data  = {16'h0, lane[15:0]};
            mask       = 32'h0000_FFFF << sh;
            store_data = (word & ~mask) | ({16'h0, data[15:0]} << sh);
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/dm_ctrl.sv
// Two-port round-robin data-memory controller: byte/half/word access on a
// word-only single-port DM, with read-modify-write for sub-word stores.
module dm_ctrl
   import dm_ctrl_pkg::*;
#(
   parameter int unsigned ADDR_W = 10
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                req_0,
   input  logic                we_0,
   input  logic [1:0]          size_0,
   input  logic [ADDR_W+1:0]   addr_0,
   input  logic [31:0]         wdata_0,
   output logic                gnt_0,
   output logic                done_0,
   output logic [31:0]         rdata_0,
   output logic                err_0,
   input  logic                req_1,
   input  logic                we_1,
   input  logic [1:0]          size_1,
   input  logic [ADDR_W+1:0]   addr_1,
   input  logic [31:0]         wdata_1,
   output logic                gnt_1,
   output logic                done_1,
   output logic [31:0]         rdata_1,
   output logic                err_1,
   output logic                dm_read,
   output logic                dm_write,
   output logic [ADDR_W-1:0]   dm_addr,
   output logic [31:0]         dm_wdata,
   input  logic [31:0]         dm_rdata
);

   localparam int unsigned BA_W = ADDR_W + 2;

   state_t            state, state_n;
   logic              last;
   logic              port;
   logic              sel;
   logic              bad;
   logic              fin;
   acc_t              acc_q, acc_sel;
   logic [BA_W-1:0]   addr_q, addr_sel;
   logic [31:0]       merge_q;
   logic [31:0]       lane_word;
   logic [31:0]       load_data;
   logic [31:0]       store_data;

   // Round-robin: on a tie the port not granted last wins.
   always_comb begin
      sel      = (req_0 & req_1) ? ~last : req_1;
      acc_sel  = sel ? {we_1, size_1, wdata_1} : {we_0, size_0, wdata_0};
      addr_sel = sel ? addr_1 : addr_0;
   end

   assign lane_word = (state == WB) ? merge_q : dm_rdata;

   dm_lane_merge u_lane (
      .size       (acc_q.size),
      .off        (addr_q[1:0]),
      .word       (lane_word),
      .data       (acc_q.wdata),
      .load_data  (load_data),
      .store_data (store_data)
   );

   always_comb begin
      state_n  = state;
      gnt_0    = 1'b0;
      gnt_1    = 1'b0;
      dm_read  = 1'b0;
      dm_write = 1'b0;
      dm_addr  = '0;
      dm_wdata = '0;
      fin      = 1'b0;
      case (state)
         IDLE: begin
            if (req_0 | req_1) begin
               gnt_0   = ~sel;
               gnt_1   = sel;
               state_n = EXEC;
            end
         end
         EXEC: begin
            state_n = IDLE;
            fin     = 1'b1;
            if (!bad) begin
               dm_addr = addr_q[BA_W-1:2];
               if (!acc_q.we) begin
                  dm_read = 1'b1;
               end else if (acc_q.size == SZ_WORD) begin
                  dm_write = 1'b1;
                  dm_wdata = acc_q.wdata;
               end else begin
                  dm_read = 1'b1;
                  fin     = 1'b0;
                  state_n = WB;
               end
            end
         end
         WB: begin
            dm_write = 1'b1;
            dm_addr  = addr_q[BA_W-1:2];
            dm_wdata = store_data;
            fin      = 1'b1;
            state_n  = IDLE;
         end
         default: state_n = IDLE;
      endcase
      // Reset suppresses grants and any DM strobe in the same cycle.
      if (rst) begin
         gnt_0    = 1'b0;
         gnt_1    = 1'b0;
         dm_read  = 1'b0;
         dm_write = 1'b0;
         dm_addr  = '0;
         dm_wdata = '0;
         fin      = 1'b0;
         state_n  = IDLE;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         last    <= 1'b1;
         port    <= 1'b0;
         bad     <= 1'b0;
         acc_q   <= '0;
         addr_q  <= '0;
         merge_q <= '0;
         done_0  <= 1'b0;
         done_1  <= 1'b0;
         err_0   <= 1'b0;
         err_1   <= 1'b0;
         rdata_0 <= '0;
         rdata_1 <= '0;
      end else begin
         state <= state_n;
         if (gnt_0 | gnt_1) begin
            port   <= sel;
            last   <= sel;
            acc_q  <= acc_sel;
            addr_q <= addr_sel;
            bad    <= misaligned(acc_sel.size, addr_sel[1:0]);
         end
         if (state == EXEC) merge_q <= dm_rdata;
         done_0  <= fin & ~port;
         done_1  <= fin & port;
         err_0   <= fin & bad & ~port;
         err_1   <= fin & bad & port;
         rdata_0 <= (fin & ~bad & ~acc_q.we & ~port) ? load_data : '0;
         rdata_1 <= (fin & ~bad & ~acc_q.we & port) ? load_data : '0;
      end
   end

endmodule

// File: tb/tb_dm_ctrl.sv
// Bench for dm_ctrl: directed and random accesses against a byte-array memory
// model, plus arbitration fairness and reset-during-RMW scenarios.
module tb_dm_ctrl;

   localparam int unsigned AW = 10;

   logic clk = 1'b0;
   logic rst;
   logic mem_clr;
   always #5 clk = ~clk;

   logic              req_0, we_0, gnt_0, done_0, err_0;
   logic [1:0]        size_0;
   logic [AW+1:0]     addr_0;
   logic [31:0]       wdata_0, rdata_0;
   logic              req_1, we_1, gnt_1, done_1, err_1;
   logic [1:0]        size_1;
   logic [AW+1:0]     addr_1;
   logic [31:0]       wdata_1, rdata_1;
   logic              dm_read, dm_write;
   logic [AW-1:0]     dm_addr;
   logic [31:0]       dm_wdata, dm_rdata;

   dm_ctrl #(.ADDR_W(AW)) dut (
      .clk(clk), .rst(rst),
      .req_0(req_0), .we_0(we_0), .size_0(size_0), .addr_0(addr_0), .wdata_0(wdata_0),
      .gnt_0(gnt_0), .done_0(done_0), .rdata_0(rdata_0), .err_0(err_0),
      .req_1(req_1), .we_1(we_1), .size_1(size_1), .addr_1(addr_1), .wdata_1(wdata_1),
      .gnt_1(gnt_1), .done_1(done_1), .rdata_1(rdata_1), .err_1(err_1),
      .dm_read(dm_read), .dm_write(dm_write), .dm_addr(dm_addr),
      .dm_wdata(dm_wdata), .dm_rdata(dm_rdata)
   );

   // Word-wide data memory: combinational read, write on the clock edge.
   logic [31:0] mem [1024];
   assign dm_rdata = mem[dm_addr];
   always @(posedge clk) begin
      if (mem_clr) begin
         for (int i = 0; i < 1024; i++) mem[i] <= '0;
      end else if (dm_write) begin
         mem[dm_addr] <= dm_wdata;
      end
   end

   // Reference: byte-addressed memory image and last-granted port.
   logic [7:0] ref_byte [4096];
   bit         last_m;
   int         vectors = 0;
   int         errors  = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input int p, input logic r, input logic w, input logic [1:0] sz,
                        input logic [AW+1:0] a, input logic [31:0] d);
      if (p == 0) begin
         req_0 = r; we_0 = w; size_0 = sz; addr_0 = a; wdata_0 = d;
      end else begin
         req_1 = r; we_1 = w; size_1 = sz; addr_1 = a; wdata_1 = d;
      end
   endtask

   function automatic bit ref_bad(input logic [1:0] sz, input logic [AW+1:0] a);
      return (sz == 2'd3) || (sz == 2'd1 && (a % 2) != 0) || (sz == 2'd2 && (a % 4) != 0);
   endfunction

   function automatic int nbytes(input logic [1:0] sz);
      return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
   endfunction

   task automatic ref_store(input logic [1:0] sz, input logic [AW+1:0] a, input logic [31:0] d);
      for (int i = 0; i < nbytes(sz); i++) ref_byte[int'(a) + i] = 8'(d >> (8 * i));
   endtask

   task automatic do_op(input int p, input logic w, input logic [1:0] sz,
                        input logic [AW+1:0] a, input logic [31:0] d, input string tag);
      logic [31:0] exp_rd;
      bit          bad, seen, strobe, both;
      int          lat, exp_lat;
      bad    = ref_bad(sz, a);
      exp_rd = '0;
      if (!bad && !w)
         for (int i = 0; i < nbytes(sz); i++) exp_rd |= 32'(ref_byte[int'(a) + i]) << (8 * i);
      exp_lat = (!bad && w && sz != 2'd2) ? 3 : 2;
      drive(p, 1'b1, w, sz, a, d);
      #1;
      check({tag, " gnt"}, 32'(p == 0 ? gnt_0 : gnt_1), 32'd1);
      check({tag, " other gnt"}, 32'(p == 0 ? gnt_1 : gnt_0), 32'd0);
      last_m = (p != 0);
      tick();
      drive(p, 1'b0, 1'b0, 2'd0, '0, '0);
      lat = 1; seen = 0; strobe = 0; both = 0;
      while (!seen && lat < 6) begin
         strobe |= (dm_read | dm_write);
         both   |= (dm_read & dm_write);
         tick();
         lat++;
         seen = (p == 0) ? done_0 : done_1;
      end
      if (!seen) lat = 99;
      check({tag, " latency"}, 32'(lat), 32'(exp_lat));
      check({tag, " rdata"}, (p == 0) ? rdata_0 : rdata_1, exp_rd);
      check({tag, " err"}, 32'(p == 0 ? err_0 : err_1), 32'(bad));
      check({tag, " other done"}, 32'(p == 0 ? done_1 : done_0), 32'd0);
      check({tag, " rd+wr"}, 32'(both), 32'd0);
      if (bad) check({tag, " no strobe"}, 32'(strobe), 32'd0);
      if (!bad && w) ref_store(sz, a, d);
   endtask

   task automatic check_idle_outs(input string tag);
      check({tag, " flags"}, 32'({gnt_0, gnt_1, done_0, done_1, err_0, err_1, dm_read, dm_write}), 32'd0);
      check({tag, " rdata0"}, rdata_0, 32'd0);
      check({tag, " rdata1"}, rdata_1, 32'd0);
      check({tag, " dm_addr/wdata"}, dm_wdata | 32'(dm_addr), 32'd0);
   endtask

   task automatic do_reset();
      drive(0, 1'b1, 1'b0, 2'd2, '0, '0);
      rst = 1'b1;
      tick();
      tick();
      check_idle_outs("reset");
      drive(0, 1'b0, 1'b0, 2'd0, '0, '0);
      rst = 1'b0;
      last_m = 1'b1;
   endtask

   task automatic arb_test(input logic w, input logic [1:0] sz, input int gap, input string tag);
      int ngr, last_t, cyc;
      bit exp_p;
      ngr = 0; last_t = -1; cyc = 0;
      drive(0, 1'b1, w, sz, 12'h040, 32'h1111_2222);
      drive(1, 1'b1, w, sz, 12'h080, 32'h3333_4444);
      while (ngr < 6 && cyc < 40) begin
         #1;
         if (gnt_0 | gnt_1) begin
            exp_p = ~last_m;
            check({tag, " winner"}, 32'(gnt_1), 32'(exp_p));
            check({tag, " single gnt"}, 32'(gnt_0 & gnt_1), 32'd0);
            if (last_t >= 0) check({tag, " spacing"}, 32'(cyc - last_t), 32'(gap));
            last_t = cyc;
            last_m = gnt_1;
            ngr++;
         end
         tick();
         cyc++;
      end
      check({tag, " grants"}, 32'(ngr), 32'd6);
      drive(0, 1'b0, 1'b0, 2'd0, '0, '0);
      drive(1, 1'b0, 1'b0, 2'd0, '0, '0);
      repeat (4) tick();
      if (w) begin
         ref_store(sz, 12'h040, 32'h1111_2222);
         ref_store(sz, 12'h080, 32'h3333_4444);
      end
   endtask

   initial begin
      logic [AW+1:0] ra;
      logic [1:0]    rs;
      for (int i = 0; i < 4096; i++) ref_byte[i] = 8'h00;
      drive(0, 1'b0, 1'b0, 2'd0, '0, '0);
      drive(1, 1'b0, 1'b0, 2'd0, '0, '0);
      rst = 1'b1;
      mem_clr = 1'b1;
      tick();
      tick();
      mem_clr = 1'b0;
      do_reset();

      // Word store/load, then sub-word RMW and lane loads.
      do_op(0, 1'b1, 2'd2, 12'h010, 32'hDEAD_BEEF, "st word");
      do_op(0, 1'b0, 2'd2, 12'h010, 32'h0, "ld word");
      do_op(0, 1'b1, 2'd0, 12'h011, 32'h0000_00AB, "st byte");
      do_op(0, 1'b0, 2'd2, 12'h010, 32'h0, "ld merged");
      do_op(0, 1'b0, 2'd0, 12'h011, 32'h0, "ld byte");
      do_op(0, 1'b0, 2'd1, 12'h012, 32'h0, "ld half");
      do_op(1, 1'b1, 2'd1, 12'h016, 32'h1234_5678, "p1 st half");
      do_op(1, 1'b0, 2'd2, 12'h014, 32'h0, "p1 ld word");
      do_op(1, 1'b0, 2'd0, 12'h017, 32'h0, "p1 ld byte3");

      // Misaligned and reserved-size requests.
      do_op(0, 1'b1, 2'd1, 12'h013, 32'hFFFF_FFFF, "mis st half");
      do_op(0, 1'b0, 2'd2, 12'h002, 32'h0, "mis ld word");
      do_op(1, 1'b0, 2'd3, 12'h000, 32'h0, "rsv size");
      do_op(1, 1'b1, 2'd2, 12'h011, 32'hFFFF_FFFF, "mis st word");
      do_op(0, 1'b0, 2'd2, 12'h010, 32'h0, "ld after err");

      do_reset();
      arb_test(1'b0, 2'd2, 2, "arb word");
      do_reset();
      arb_test(1'b1, 2'd0, 3, "arb rmw");

      // Reset during the write-back cycle of a byte store.
      drive(0, 1'b1, 1'b1, 2'd0, 12'h021, 32'h0000_0055);
      #1;
      check("rstwb gnt", 32'(gnt_0), 32'd1);
      tick();
      drive(0, 1'b0, 1'b0, 2'd0, '0, '0);
      tick();
      rst = 1'b1;
      #1;
      check("rstwb no write", 32'(dm_write), 32'd0);
      tick();
      check("rstwb no done", 32'(done_0 | done_1), 32'd0);
      rst = 1'b0;
      last_m = 1'b1;
      do_op(0, 1'b0, 2'd2, 12'h020, 32'h0, "after rst ld");

      // Random traffic over a small window so loads hit prior stores.
      for (int n = 0; n < 80; n++) begin
         rs = 2'($urandom_range(0, 3));
         ra = (AW + 2)'($urandom_range(0, 127));
         if ($urandom_range(0, 3) != 0 && rs != 2'd3) ra = ra & ~((AW + 2)'(nbytes(rs) - 1));
         do_op(int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rs, ra, $urandom,
               $sformatf("rnd%0d", n));
      end

      for (int w = 0; w < 40; w++)
         check($sformatf("mem word %0d", w), mem[w],
               {ref_byte[4*w+3], ref_byte[4*w+2], ref_byte[4*w+1], ref_byte[4*w]});

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
